// File: rtl/sdram_port_arbiter_if.sv
// Memory-side bus between the port arbiter and the SDRAM sequencer.
// The arbiter drives the access parameters. The sequencer answers with a one-cycle done strobe and the read data.
interface sdram_port_arbiter_if #(
  parameter int AW = 25
);
  logic          mem_start;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_din;
  logic          mem_done;
  logic [15:0]   mem_rdata;

  modport master (
    output mem_start, mem_addr, mem_we, mem_din,
    input  mem_done, mem_rdata
  );

  modport slave (
    input  mem_start, mem_addr, mem_we, mem_din,
    output mem_done, mem_rdata
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Three-client toggle-handshake arbiter (char > rom > tape) in front of a single SDRAM sequencer.
// Includes a tape anti-starvation counter and a WAIT-state timeout.
module sdram_port_arbiter #(
  parameter int AW  = 25,
  parameter int TMO = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clkref,
  input  logic                  sync_en,
  input  logic                  rom_req,
  input  logic                  char_req,
  input  logic                  tape_req,
  output logic                  rom_ack,
  output logic                  char_ack,
  output logic                  tape_ack,
  input  logic [AW-1:0]         rom_addr,
  input  logic [AW-1:0]         char_addr,
  input  logic [AW-1:0]         tape_addr,
  input  logic                  rom_we,
  input  logic                  char_we,
  input  logic                  tape_we,
  input  logic [7:0]            rom_din,
  input  logic [7:0]            char_din,
  input  logic [7:0]            tape_din,
  output logic [15:0]           rom_dout,
  output logic [15:0]           char_dout,
  output logic [15:0]           tape_dout,
  sdram_port_arbiter_if.master  mem,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  tmo_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t      state, state_nx;
  logic [1:0]  starv;
  logic [7:0]  wait_cnt;
  logic        rom_pend, char_pend, tape_pend, go, tmo_hit, finish;
  logic [1:0]  win;
  logic [15:0] rd_val;

  assign rom_pend  = rom_req  != rom_ack;
  assign char_pend = char_req != char_ack;
  assign tape_pend = tape_req != tape_ack;
  assign go        = (rom_pend || char_pend || tape_pend) && (clkref || !sync_en);
  assign tmo_hit   = (state == WAIT) && !mem.mem_done && (wait_cnt == TMO_LAST);
  assign finish    = (state == WAIT) && (mem.mem_done || tmo_hit);
  assign rd_val    = mem.mem_done ? mem.mem_rdata : 16'hFFFF;

  // A saturated starvation counter lets a pending tape jump the queue once.
  always_comb begin
    win = 2'd0;
    if (starv == 2'd3 && tape_pend) win = 2'd3;
    else if (char_pend)             win = 2'd1;
    else if (rom_pend)              win = 2'd2;
    else if (tape_pend)             win = 2'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_start = (state == ISSUE);
    busy          = (state != IDLE);
  end

  // Datapath: request latching, completion write-back, ack toggles and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_ack      <= 1'b0;
      char_ack     <= 1'b0;
      tape_ack     <= 1'b0;
      rom_dout     <= 16'h0000;
      char_dout    <= 16'h0000;
      tape_dout    <= 16'h0000;
      mem.mem_addr <= '0;
      mem.mem_we   <= 1'b0;
      mem.mem_din  <= 8'h00;
      grant        <= 2'd0;
      tmo_err      <= 1'b0;
      starv        <= 2'd0;
      wait_cnt     <= 8'd0;
    end else begin
      tmo_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!tape_pend) starv <= 2'd0;
          if (go) begin
            grant <= win;
            case (win)
              2'd1: begin
                mem.mem_addr <= char_addr;
                mem.mem_we   <= char_we;
                mem.mem_din  <= char_din;
              end
              2'd2: begin
                mem.mem_addr <= rom_addr;
                mem.mem_we   <= rom_we;
                mem.mem_din  <= rom_din;
              end
              default: begin
                mem.mem_addr <= tape_addr;
                mem.mem_we   <= tape_we;
                mem.mem_din  <= tape_din;
              end
            endcase
            if (win == 2'd3)                      starv <= 2'd0;
            else if (tape_pend && starv != 2'd3)  starv <= starv + 2'd1;
          end
        end
        ISSUE: wait_cnt <= 8'd0;
        WAIT: begin
          if (finish) begin
            grant   <= 2'd0;
            tmo_err <= tmo_hit;
            case (grant)
              2'd1: begin
                char_ack <= ~char_ack;
                if (!mem.mem_we) char_dout <= rd_val;
              end
              2'd2: begin
                rom_ack <= ~rom_ack;
                if (!mem.mem_we) rom_dout <= rd_val;
              end
              2'd3: begin
                tape_ack <= ~tape_ack;
                if (!mem.mem_we) tape_dout <= rd_val;
              end
              default: ;
            endcase
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: the bench plays the SDRAM sequencer and the three clients.
// Every expected value below is worked out by hand from the arbiter's intended behaviour.
module tb_sdram_port_arbiter;

  localparam int AW  = 25;
  localparam int TMO = 10;

  logic clk = 1'b0, reset = 1'b1, clkref = 1'b0, sync_en = 1'b0;
  logic rom_req = 1'b0, char_req = 1'b0, tape_req = 1'b0;
  logic rom_ack, char_ack, tape_ack;
  logic [AW-1:0] rom_addr = '0, char_addr = '0, tape_addr = '0;
  logic rom_we = 1'b0, char_we = 1'b0, tape_we = 1'b0;
  logic [7:0] rom_din = 8'h00, char_din = 8'h00, tape_din = 8'h00;
  logic [15:0] rom_dout, char_dout, tape_dout;
  logic [1:0] grant;
  logic busy, tmo_err;

  int errors = 0;
  int checks = 0;

  sdram_port_arbiter_if #(.AW(AW)) mem ();

  sdram_port_arbiter #(.AW(AW), .TMO(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .clkref    (clkref),
    .sync_en   (sync_en),
    .rom_req   (rom_req),
    .char_req  (char_req),
    .tape_req  (tape_req),
    .rom_ack   (rom_ack),
    .char_ack  (char_ack),
    .tape_ack  (tape_ack),
    .rom_addr  (rom_addr),
    .char_addr (char_addr),
    .tape_addr (tape_addr),
    .rom_we    (rom_we),
    .char_we   (char_we),
    .tape_we   (tape_we),
    .rom_din   (rom_din),
    .char_din  (char_din),
    .tape_din  (tape_din),
    .rom_dout  (rom_dout),
    .char_dout (char_dout),
    .tape_dout (tape_dout),
    .mem       (mem),
    .grant     (grant),
    .busy      (busy),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (mem.mem_start !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_output(tag, {31'd0, mem.mem_start}, 32'd1);
  endtask

  // Called in the ISSUE cycle: answer with mem_done in the first WAIT cycle.
  task automatic serve(input logic [15:0] rdata);
    step();
    mem.mem_done  = 1'b1;
    mem.mem_rdata = rdata;
    step();
    mem.mem_done  = 1'b0;
  endtask

  initial begin
    int starve_exp[4];
    int start_cnt;
    int first_start;
    int n;
    logic saved_ack;

    starve_exp    = '{1, 1, 1, 3};
    mem.mem_done  = 1'b0;
    mem.mem_rdata = 16'h0000;

    step();
    step();
    check_output("reset_acks",  {29'd0, rom_ack, char_ack, tape_ack}, 32'd0);
    check_output("reset_douts", {rom_dout | char_dout | tape_dout}, 32'd0);
    check_output("reset_ctrl",  {28'd0, grant, busy, tmo_err}, 32'd0);
    check_output("reset_mem",   {6'd0, mem.mem_addr, mem.mem_we}, 32'd0);
    check_output("reset_start", {31'd0, mem.mem_start}, 32'd0);
    reset = 1'b0;
    step();

    $display("[TB] single read");
    rom_addr = 25'h1234;
    rom_req  = 1'b1;
    step();
    check_output("read_start", {31'd0, mem.mem_start}, 32'd1);
    check_output("read_addr",  {7'd0, mem.mem_addr}, 32'h1234);
    check_output("read_grant", {30'd0, grant}, 32'd2);
    check_output("read_busy",  {31'd0, busy}, 32'd1);
    step();
    check_output("read_start_once", {31'd0, mem.mem_start}, 32'd0);
    step();
    step();
    check_output("read_ack_early", {31'd0, rom_ack}, 32'd0);
    mem.mem_done  = 1'b1;
    mem.mem_rdata = 16'hABCD;
    step();
    mem.mem_done  = 1'b0;
    check_output("read_ack",     {31'd0, rom_ack}, 32'd1);
    check_output("read_dout",    {16'd0, rom_dout}, 32'hABCD);
    check_output("read_idle",    {29'd0, grant, busy}, 32'd0);
    check_output("read_others",  {14'd0, char_ack, tape_ack, char_dout}, 32'd0);

    $display("[TB] write with turnaround and ignored done in ISSUE");
    rom_addr = 25'h0042;
    rom_we   = 1'b1;
    rom_din  = 8'h5A;
    rom_req  = 1'b0;
    step();
    check_output("turn_start", {31'd0, mem.mem_start}, 32'd1);
    check_output("write_params", {mem.mem_we, 6'd0, mem.mem_addr}, {1'b1, 6'd0, 25'h0042});
    check_output("write_din", {24'd0, mem.mem_din}, 32'h5A);
    mem.mem_done = 1'b1;
    step();
    mem.mem_done = 1'b0;
    check_output("issue_done_ignored", {30'd0, rom_ack, busy}, 32'b11);
    mem.mem_done  = 1'b1;
    mem.mem_rdata = 16'h1111;
    step();
    mem.mem_done  = 1'b0;
    check_output("write_ack",  {31'd0, rom_ack}, 32'd0);
    check_output("write_keep", {16'd0, rom_dout}, 32'hABCD);
    check_output("write_idle", {31'd0, busy}, 32'd0);
    rom_we = 1'b0;

    $display("[TB] contention");
    char_addr = 25'h100;
    rom_addr  = 25'h200;
    tape_addr = 25'h300;
    char_req  = 1'b1;
    rom_req   = 1'b1;
    tape_req  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_start($sformatf("contend_start%0d", i));
      check_output($sformatf("contend_grant%0d", i), {30'd0, grant}, i);
      check_output($sformatf("contend_addr%0d", i), {7'd0, mem.mem_addr}, 32'h100 * i);
      serve(16'hC000 + 16'(i));
    end
    check_output("contend_acks", {29'd0, char_ack, rom_ack, tape_ack}, 32'b111);
    check_output("contend_char_dout", {16'd0, char_dout}, 32'hC001);
    check_output("contend_rom_dout",  {16'd0, rom_dout},  32'hC002);
    check_output("contend_tape_dout", {16'd0, tape_dout}, 32'hC003);

    $display("[TB] starvation");
    char_req = ~char_ack;
    rom_req  = ~rom_ack;
    tape_req = ~tape_ack;
    for (int i = 0; i < 4; i++) begin
      wait_start($sformatf("starve_start%0d", i));
      check_output($sformatf("starve_grant%0d", i), {30'd0, grant}, starve_exp[i]);
      serve(16'h5000 + 16'(i));
      if (i < 3) begin
        char_req = ~char_ack;
        rom_req  = ~rom_ack;
      end
    end
    wait_start("drain_start0");
    check_output("drain_grant0", {30'd0, grant}, 32'd1);
    serve(16'h6000);
    wait_start("drain_start1");
    check_output("drain_grant1", {30'd0, grant}, 32'd2);
    serve(16'h6001);

    $display("[TB] clkref-aligned start");
    sync_en     = 1'b1;
    start_cnt   = 0;
    first_start = -1;
    for (int k = 0; k < 24; k++) begin
      clkref = (k % 8 == 0);
      if (k == 1) begin
        rom_addr = 25'h77;
        rom_req  = ~rom_ack;
      end
      if (k == 11) begin
        mem.mem_done  = 1'b1;
        mem.mem_rdata = 16'h0BEE;
      end
      if (k == 12) mem.mem_done = 1'b0;
      if (mem.mem_start === 1'b1) begin
        start_cnt++;
        if (first_start < 0) first_start = k;
      end
      step();
    end
    clkref  = 1'b0;
    sync_en = 1'b0;
    check_output("sync_first_start", first_start, 32'd9);
    check_output("sync_start_count", start_cnt, 32'd1);
    check_output("sync_dout", {16'd0, rom_dout}, 32'h0BEE);

    $display("[TB] timeout");
    tape_addr = 25'h3AA;
    saved_ack = tape_ack;
    tape_req  = ~tape_ack;
    wait_start("tmo_start");
    step();
    n = 0;
    while (tmo_err !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check_output("tmo_latency", n, 32'd10);
    check_output("tmo_dout", {16'd0, tape_dout}, 32'hFFFF);
    check_output("tmo_ack", {31'd0, tape_ack}, {31'd0, ~saved_ack});
    check_output("tmo_idle", {29'd0, grant, busy}, 32'd0);
    step();
    check_output("tmo_pulse_once", {31'd0, tmo_err}, 32'd0);

    $display("[TB] done coincident with timeout");
    saved_ack = tape_ack;
    tape_req  = ~tape_ack;
    wait_start("tie_start");
    step();
    repeat (9) step();
    mem.mem_done  = 1'b1;
    mem.mem_rdata = 16'h2222;
    step();
    mem.mem_done  = 1'b0;
    check_output("tie_no_tmo", {31'd0, tmo_err}, 32'd0);
    check_output("tie_dout", {16'd0, tape_dout}, 32'h2222);
    check_output("tie_ack", {31'd0, tape_ack}, {31'd0, ~saved_ack});
    check_output("tie_idle", {31'd0, busy}, 32'd0);

    $display("[TB] reset during WAIT");
    rom_addr = 25'h55;
    rom_req  = ~rom_ack;
    wait_start("rst_start");
    step();
    check_output("rst_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_output("rst_async_ctrl", {28'd0, grant, busy, tmo_err}, 32'd0);
    check_output("rst_async_acks", {29'd0, rom_ack, char_ack, tape_ack}, 32'd0);
    check_output("rst_async_douts", {16'd0, rom_dout | char_dout | tape_dout}, 32'd0);
    check_output("rst_async_mem", {6'd0, mem.mem_addr, mem.mem_we}, 32'd0);
    rom_req  = 1'b0;
    char_req = 1'b0;
    tape_req = 1'b0;
    step();
    reset        = 1'b0;
    mem.mem_done = 1'b1;
    step();
    mem.mem_done = 1'b0;
    start_cnt = 0;
    repeat (5) begin
      if (mem.mem_start === 1'b1) start_cnt++;
      step();
    end
    check_output("rst_no_start", start_cnt, 32'd0);
    check_output("rst_no_ack", {29'd0, rom_ack, char_ack, tape_ack}, 32'd0);
    check_output("rst_idle", {31'd0, busy}, 32'd0);
    char_addr = 25'h99;
    char_req  = 1'b1;
    wait_start("post_rst_start");
    check_output("post_rst_grant", {30'd0, grant}, 32'd1);
    serve(16'h4321);
    check_output("post_rst_ack", {31'd0, char_ack}, 32'd1);
    check_output("post_rst_dout", {16'd0, char_dout}, 32'h4321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
